// File: rtl/fighter_pkg.sv
// Shared types and constants for the fighter attack logic.
package fighter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STARTUP  = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_RECOVERY = 3'd3,
        ST_STUN     = 3'd4
    } attack_state_t;

    localparam logic [7:0] P1_ATK_KEY  = 8'h09;
    localparam logic [7:0] P2_ATK_KEY  = 8'h0F;
    localparam int         STARTUP_FR  = 4;
    localparam int         ACTIVE_FR   = 3;
    localparam int         RECOVERY_FR = 6;
    localparam int         HITSTUN_FR  = 10;
    localparam logic [9:0] REACH       = 10'd48;
    localparam logic [9:0] Y_TOL       = 10'd32;

    // Absolute difference of two pixel coordinates, widened so no wrap can occur.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] a_ext;
        logic [10:0] b_ext;
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        return (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
    endfunction

endpackage

// File: rtl/attack_fsm.sv
// Per-player attack sequencer with a frame-based down-counter.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   IDLE     | waiting for a fresh press
//   STARTUP  | wind-up, cannot hit yet
//   ACTIVE   | hitbox live; one connect allowed per attack
//   RECOVERY | cool-down, cannot start a new attack
//   STUN     | took a hit; any phase is cancelled, re-hit restarts
module attack_fsm
    import fighter_pkg::*;
#(
    parameter int STARTUP_LEN  = STARTUP_FR,
    parameter int ACTIVE_LEN   = ACTIVE_FR,
    parameter int RECOVERY_LEN = RECOVERY_FR,
    parameter int HITSTUN_LEN  = HITSTUN_FR
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       press,
    input  logic       got_hit,
    input  logic       landed,
    output logic [2:0] state,
    output logic       is_active,
    output logic       has_hit
);

    localparam logic [3:0] STARTUP_LD  = 4'(STARTUP_LEN - 1);
    localparam logic [3:0] ACTIVE_LD   = 4'(ACTIVE_LEN - 1);
    localparam logic [3:0] RECOVERY_LD = 4'(RECOVERY_LEN - 1);
    localparam logic [3:0] HITSTUN_LD  = 4'(HITSTUN_LEN - 1);

    attack_state_t state_q;
    logic [3:0]    cnt;

    // Phase sequencing; a hit overrides both the press and the normal advance.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt     <= 4'd0;
            has_hit <= 1'b0;
        end else if (frame_tick) begin
            if (landed) has_hit <= 1'b1;
            if (got_hit) begin
                state_q <= ST_STUN;
                cnt     <= HITSTUN_LD;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (press) begin
                            state_q <= ST_STARTUP;
                            cnt     <= STARTUP_LD;
                            has_hit <= 1'b0;
                        end
                    end
                    ST_STARTUP: begin
                        if (cnt == 4'd0) begin
                            state_q <= ST_ACTIVE;
                            cnt     <= ACTIVE_LD;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (cnt == 4'd0) begin
                            state_q <= ST_RECOVERY;
                            cnt     <= RECOVERY_LD;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    ST_RECOVERY, ST_STUN: begin
                        if (cnt == 4'd0) state_q <= ST_IDLE;
                        else             cnt     <= cnt - 4'd1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt     <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign state     = state_q;
    assign is_active = (state_q == ST_ACTIVE);

endmodule

// File: rtl/attack_resolver.sv
// Two-player punch sequencing and hit resolution between position and health logic.
module attack_resolver
    import fighter_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode_0,
    input  logic [7:0] keycode_1,
    input  logic [7:0] keycode_2,
    input  logic [7:0] keycode_3,
    input  logic [9:0] Player1X,
    input  logic [9:0] Player1Y,
    input  logic [9:0] Player2X,
    input  logic [9:0] Player2Y,
    output logic       ryu_hit,
    output logic       akuma_hit,
    output logic [2:0] p1_state,
    output logic [2:0] p2_state
);

    logic        pressed1, pressed2;
    logic        prev1, prev2;
    logic        armed1, armed2;
    logic        press1, press2;
    logic [10:0] dx, dy;
    logic        in_range;
    logic        p1_active, p2_active;
    logic        p1_has_hit, p2_has_hit;
    logic        connect1, connect2;

    assign pressed1 = (keycode_0 == P1_ATK_KEY) || (keycode_1 == P1_ATK_KEY) ||
                      (keycode_2 == P1_ATK_KEY) || (keycode_3 == P1_ATK_KEY);
    assign pressed2 = (keycode_0 == P2_ATK_KEY) || (keycode_1 == P2_ATK_KEY) ||
                      (keycode_2 == P2_ATK_KEY) || (keycode_3 == P2_ATK_KEY);

    // Key history; armed stays low after reset until the key is seen released,
    // so a key held through reset cannot fire an attack.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev1  <= 1'b0;
            prev2  <= 1'b0;
            armed1 <= 1'b0;
            armed2 <= 1'b0;
        end else if (frame_tick) begin
            prev1 <= pressed1;
            prev2 <= pressed2;
            if (!pressed1) armed1 <= 1'b1;
            if (!pressed2) armed2 <= 1'b1;
        end
    end

    assign press1 = pressed1 && !prev1 && armed1;
    assign press2 = pressed2 && !prev2 && armed2;

    assign dx       = abs_diff(Player1X, Player2X);
    assign dy       = abs_diff(Player1Y, Player2Y);
    assign in_range = (dx <= {1'b0, REACH}) && (dy <= {1'b0, Y_TOL});

    assign connect1 = p1_active && in_range && !p1_has_hit;
    assign connect2 = p2_active && in_range && !p2_has_hit;

    attack_fsm u_p1_fsm (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .press      (press1),
        .got_hit    (connect2),
        .landed     (connect1),
        .state      (p1_state),
        .is_active  (p1_active),
        .has_hit    (p1_has_hit)
    );

    attack_fsm u_p2_fsm (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .press      (press2),
        .got_hit    (connect1),
        .landed     (connect2),
        .state      (p2_state),
        .is_active  (p2_active),
        .has_hit    (p2_has_hit)
    );

    // Single-cycle hit pulses following the connecting tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ryu_hit   <= 1'b0;
            akuma_hit <= 1'b0;
        end else begin
            ryu_hit   <= frame_tick && connect2;
            akuma_hit <= frame_tick && connect1;
        end
    end

endmodule
